// File: rtl/ex_flag_stage.sv
// ex_flag_stage: IITB-RISC execute stage ALU, carry/zero flag registers and
// the EX/MEM pipeline register.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            instruction present in EX
//   stall / flush       hold EX/MEM / kill instruction in EX (flush wins)
//   alu_op              00 add, 01 nand, 10 pass/cancel, 11 subtract-compare
//   carry_write_en      carry flag write enable from ALU control
//   zero_write_en       zero flag write enable from ALU control
//   reg_write_en        qualified register write enable from ALU control
//   op_a, op_b, dest    operands and destination index
//   carry_flag          architectural carry flag (register output)
//   zero_flag           architectural zero flag (register output)
//   out_*               registered EX/MEM entry
//   cancel_cnt          saturating count of predicated-off instructions
module ex_flag_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       alu_op,
  input  logic             carry_write_en,
  input  logic             zero_write_en,
  input  logic             reg_write_en,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       dest,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_dest,
  output logic             out_reg_write_en,
  output logic             out_eq,
  output logic [CNT_W-1:0] cancel_cnt
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] result;
    logic [2:0]       dest;
    logic             rwe;
    logic             eq;
  } exmem_t;

  exmem_t exmem_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r;
  logic             c_cand;
  logic             z_cand;
  logic             eq;
  logic             fire;
  logic             cancel;

  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  // Top bit of the extended difference is the unsigned borrow (op_a < op_b).
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    r      = op_a;
    c_cand = carry_flag;
    unique case (alu_op)
      OP_ADD:  begin r = sum[WIDTH-1:0];  c_cand = sum[WIDTH];  end
      OP_NAND: begin r = ~(op_a & op_b);  c_cand = carry_flag;  end
      OP_PASS: begin r = op_a;            c_cand = carry_flag;  end
      OP_SUB:  begin r = diff[WIDTH-1:0]; c_cand = diff[WIDTH]; end
      default: begin r = op_a;            c_cand = carry_flag;  end
    endcase
  end

  assign z_cand = (r == '0);
  assign eq     = (alu_op == OP_SUB) & z_cand;
  assign fire   = in_valid & ~stall & ~flush;
  assign cancel = (alu_op == OP_PASS) & ~reg_write_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      exmem_q    <= '0;
      cancel_cnt <= '0;
    end else if (flush) begin
      // Killed instruction: bubble only, no architectural side effects.
      exmem_q.vld <= 1'b0;
      exmem_q.rwe <= 1'b0;
      exmem_q.eq  <= 1'b0;
    end else if (stall) begin
      // Hold everything; the instruction is re-presented next cycle.
    end else if (fire) begin
      if (carry_write_en) carry_flag <= c_cand;
      if (zero_write_en)  zero_flag  <= z_cand;
      exmem_q <= '{vld: 1'b1, result: r, dest: dest, rwe: reg_write_en, eq: eq};
      if (cancel && (cancel_cnt != '1)) cancel_cnt <= cancel_cnt + 1'b1;
    end else begin
      // Empty slot: bubble; result/dest keep their old contents.
      exmem_q.vld <= 1'b0;
      exmem_q.rwe <= 1'b0;
      exmem_q.eq  <= 1'b0;
    end
  end

  assign out_valid        = exmem_q.vld;
  assign out_result       = exmem_q.result;
  assign out_dest         = exmem_q.dest;
  assign out_reg_write_en = exmem_q.rwe;
  assign out_eq           = exmem_q.eq;

endmodule

// File: tb/tb_ex_flag_stage.sv
module tb_ex_flag_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, stall, flush;
  logic [1:0]  alu_op;
  logic        carry_write_en, zero_write_en, reg_write_en;
  logic [15:0] op_a, op_b;
  logic [2:0]  dest;
  logic        carry_flag, zero_flag, out_valid, out_reg_write_en, out_eq;
  logic [15:0] out_result;
  logic [2:0]  out_dest;
  logic [7:0]  cancel_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ex_flag_stage #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op), .carry_write_en(carry_write_en), .zero_write_en(zero_write_en),
    .reg_write_en(reg_write_en), .op_a(op_a), .op_b(op_b), .dest(dest),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .out_valid(out_valid),
    .out_result(out_result), .out_dest(out_dest), .out_reg_write_en(out_reg_write_en),
    .out_eq(out_eq), .cancel_cnt(cancel_cnt)
  );

  typedef struct {
    logic        rst, iv, st, fl;
    logic [1:0]  op;
    logic        cwe, zwe, rwe;
    logic [15:0] a, b;
    logic [2:0]  d;
    logic        e_vld;
    logic [15:0] e_res;
    logic [2:0]  e_dest;
    logic        e_rwe, e_eq, e_c, e_z;
    logic [7:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic r, iv, st, fl, input logic [1:0] op, input logic cwe, zwe, rwe,
    input logic [15:0] a, b, input logic [2:0] d,
    input logic ev, input logic [15:0] er, input logic [2:0] ed,
    input logic erwe, eeq, ec, ez, input logic [7:0] ecnt);
    vec_t v;
    v.rst = r; v.iv = iv; v.st = st; v.fl = fl; v.op = op;
    v.cwe = cwe; v.zwe = zwe; v.rwe = rwe; v.a = a; v.b = b; v.d = d;
    v.e_vld = ev; v.e_res = er; v.e_dest = ed; v.e_rwe = erwe; v.e_eq = eeq;
    v.e_c = ec; v.e_z = ez; v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst = v.rst; in_valid = v.iv; stall = v.st; flush = v.fl; alu_op = v.op;
    carry_write_en = v.cwe; zero_write_en = v.zwe; reg_write_en = v.rwe;
    op_a = v.a; op_b = v.b; dest = v.d;
    @(posedge clk); #1;
    chk("out_valid",  idx, 16'(out_valid),        16'(v.e_vld));
    chk("out_result", idx, out_result,            v.e_res);
    chk("out_dest",   idx, 16'(out_dest),         16'(v.e_dest));
    chk("out_rwe",    idx, 16'(out_reg_write_en), 16'(v.e_rwe));
    chk("out_eq",     idx, 16'(out_eq),           16'(v.e_eq));
    chk("carry_flag", idx, 16'(carry_flag),       16'(v.e_c));
    chk("zero_flag",  idx, 16'(zero_flag),        16'(v.e_z));
    chk("cancel_cnt", idx, 16'(cancel_cnt),       16'(v.e_cnt));
  endtask

  vec_t tbl[9];

  initial begin
    //            rst iv st fl op    cwe zwe rwe a         b         d  | vld res       dest rwe eq c z cnt
    tbl[0] = mk(1, 1, 0, 0, 2'b00, 1, 1, 1, 16'hFFFF, 16'h0001, 3'd1, 0, 16'h0000, 3'd0, 0, 0, 0, 0, 8'd0);
    tbl[1] = mk(0, 1, 0, 0, 2'b00, 1, 1, 1, 16'hFFFF, 16'h0001, 3'd1, 1, 16'h0000, 3'd1, 1, 0, 1, 1, 8'd0);
    tbl[2] = mk(0, 1, 0, 0, 2'b01, 0, 1, 1, 16'hF0F0, 16'hFF00, 3'd2, 1, 16'h0FFF, 3'd2, 1, 0, 1, 0, 8'd0);
    tbl[3] = mk(0, 1, 0, 0, 2'b00, 1, 1, 1, 16'h1234, 16'h1111, 3'd3, 1, 16'h2345, 3'd3, 1, 0, 0, 0, 8'd0);
    tbl[4] = mk(0, 1, 0, 0, 2'b11, 1, 1, 0, 16'h1234, 16'h1234, 3'd4, 1, 16'h0000, 3'd4, 0, 1, 0, 1, 8'd0);
    tbl[5] = mk(0, 1, 0, 0, 2'b11, 1, 1, 0, 16'h1234, 16'h1235, 3'd5, 1, 16'hFFFF, 3'd5, 0, 0, 1, 0, 8'd0);
    tbl[6] = mk(0, 0, 0, 0, 2'b00, 1, 1, 1, 16'h0001, 16'h0001, 3'd6, 0, 16'hFFFF, 3'd5, 0, 0, 1, 0, 8'd0);
    tbl[7] = mk(0, 1, 0, 0, 2'b10, 0, 0, 1, 16'h00AB, 16'h0000, 3'd6, 1, 16'h00AB, 3'd6, 1, 0, 1, 0, 8'd0);
    // Reset over a valid instruction with stall and flush also asserted.
    tbl[8] = mk(1, 1, 1, 1, 2'b00, 1, 1, 1, 16'hFFFF, 16'h0001, 3'd7, 0, 16'h0000, 3'd0, 0, 0, 0, 0, 8'd0);

    for (int i = 0; i < 9; i++) apply(tbl[i], i);

    // Set carry and zero, then 300 predicated-off ops: flags hold, counter saturates.
    apply(mk(0, 1, 0, 0, 2'b00, 1, 1, 1, 16'hFFFF, 16'h0001, 3'd1,
             1, 16'h0000, 3'd1, 1, 0, 1, 1, 8'd0), 100);
    for (int i = 0; i < 300; i++)
      apply(mk(0, 1, 0, 0, 2'b10, 0, 0, 0, 16'h0005, 16'h0009, 3'd0,
               1, 16'h0005, 3'd0, 0, 0, 1, 1, (i >= 254) ? 8'hFF : 8'(i + 1)), 200 + i);

    // ADD 3+4 stalled three cycles: entry and flags frozen.
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 1, 0, 2'b00, 1, 1, 1, 16'h0003, 16'h0004, 3'd7,
               1, 16'h0005, 3'd0, 0, 0, 1, 1, 8'hFF), 600 + i);
    // Release: single fire, one flag update (carry 0, zero 0).
    apply(mk(0, 1, 0, 0, 2'b00, 1, 1, 1, 16'h0003, 16'h0004, 3'd7,
             1, 16'h0007, 3'd7, 1, 0, 0, 0, 8'hFF), 610);

    // Flush of a carry/zero-producing ADD: bubble, flags unchanged.
    apply(mk(0, 1, 0, 1, 2'b00, 1, 1, 1, 16'hFFFF, 16'h0001, 3'd2,
             0, 16'h0007, 3'd7, 0, 0, 0, 0, 8'hFF), 620);
    // Valid entry, then flush together with stall still bubbles.
    apply(mk(0, 1, 0, 0, 2'b11, 0, 0, 1, 16'h0042, 16'h0042, 3'd3,
             1, 16'h0000, 3'd3, 1, 1, 0, 0, 8'hFF), 621);
    apply(mk(0, 1, 1, 1, 2'b00, 1, 1, 1, 16'hFFFF, 16'h0001, 3'd2,
             0, 16'h0000, 3'd3, 0, 0, 0, 0, 8'hFF), 622);
    // Predicated-off op under flush must not count (already saturated, so use reset first).
    apply(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 16'h0000, 16'h0000, 3'd0,
             0, 16'h0000, 3'd0, 0, 0, 0, 0, 8'd0), 630);
    apply(mk(0, 1, 0, 1, 2'b10, 0, 0, 0, 16'h0011, 16'h0000, 3'd1,
             0, 16'h0000, 3'd0, 0, 0, 0, 0, 8'd0), 631);
    apply(mk(0, 1, 1, 0, 2'b10, 0, 0, 0, 16'h0011, 16'h0000, 3'd1,
             0, 16'h0000, 3'd0, 0, 0, 0, 0, 8'd0), 632);
    apply(mk(0, 1, 0, 0, 2'b10, 0, 0, 0, 16'h0011, 16'h0000, 3'd1,
             1, 16'h0011, 3'd1, 0, 0, 0, 0, 8'd1), 633);

    // SUB-compare equal, not equal, then reset.
    apply(mk(0, 1, 0, 0, 2'b11, 1, 1, 1, 16'h1234, 16'h1234, 3'd4,
             1, 16'h0000, 3'd4, 1, 1, 0, 1, 8'd1), 640);
    apply(mk(0, 1, 0, 0, 2'b11, 1, 1, 1, 16'h1234, 16'h1235, 3'd5,
             1, 16'hFFFF, 3'd5, 1, 0, 1, 0, 8'd1), 641);
    apply(mk(1, 1, 0, 0, 2'b00, 1, 1, 1, 16'h0001, 16'h0002, 3'd6,
             0, 16'h0000, 3'd0, 0, 0, 0, 0, 8'd0), 642);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
